udp_frame_packer: RTL and testbench

Re-joins the split streams that background subtraction produces into one Avalon-ST packet for the UDP transmitter. The streams are the 3-word frame header (to_udp side) and the 160-word processed data stream. The block buffers the header, streams the data words through with zero added latency, enforces the data length, and appends one status trailer word carrying a frame counter, the bkg_sub_on flag and error flags. It sits between the background-subtraction stage and the UDP payload source.

---
 rtl/udp_frame_packer_pkg.sv | 38 +++
 rtl/udp_frame_packer_if.sv | 24 ++
 rtl/udp_frame_packer_hdr_buf.sv | 135 +++++++++++++
 rtl/udp_frame_packer.sv | 221 ++++++++++++++++++++++
 tb/tb_udp_frame_packer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_frame_packer_pkg.sv
// Shared definitions for the UDP frame packer.
// Holds the FSM state encoding, the default frame geometry, the trailer word
// bit positions and a helper that assembles the trailer word.
package udp_frame_pack_pkg;

  // Default frame geometry
  localparam int DEF_HDR_WORDS  = 3;
  localparam int DEF_DATA_WORDS = 160;

  // FSM state encoding
  localparam logic [2:0] S_COLLECT = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PAD     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_TRAIL   = 3'd5;

  // Trailer word layout
  localparam int BKG_BIT     = 31;
  localparam int LEN_ERR_BIT = 30;
  localparam int HDR_ERR_BIT = 29;
  localparam int FCNT_W      = 27;

  // Assemble the status trailer; bits [28:27] stay zero.
  function automatic logic [31:0] build_trailer(input logic              bkg,
                                                input logic              len_err,
                                                input logic              hdr_err,
                                                input logic [FCNT_W-1:0] fcnt);
    logic [31:0] w;
    w               = 32'd0;
    w[BKG_BIT]      = bkg;
    w[LEN_ERR_BIT]  = len_err;
    w[HDR_ERR_BIT]  = hdr_err;
    w[FCNT_W-1:0]   = fcnt;
    return w;
  endfunction

endpackage

// File: rtl/udp_frame_packer_if.sv
// Avalon-ST stream bundle (ready latency 0) used for the header sink, the
// data sink and the packet source of the UDP frame packer.
//   master : drives data/valid/startofpacket/endofpacket/empty, samples ready
//   slave  : samples data/valid/startofpacket/endofpacket/empty, drives ready
interface udp_frame_packer_if #(
  parameter int DW = 32
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          startofpacket;
  logic          endofpacket;
  logic [1:0]    empty;

  modport master (
    output data, valid, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket, empty,
    output ready
  );
endinterface

// File: rtl/udp_frame_packer_hdr_buf.sv
// Header buffer for the UDP frame packer.
// Collects up to N header words (sop/eop framed), flags malformed headers and
// replays the stored words through a read index.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   wr_en_i              header word accepted this cycle
//   wr_data_i/sop/eop    accepted word and its framing flags
//   rd_adv_i             advance read index (header word sent)
//   clr_err_i            clear hdr_err (frame finished)
//   rd_data_o            word at read index
//   rd_first_o/rd_last_o read index is at first / last slot
//   done_o               accepted word completes the header
//   hdr_err_o            header was short or restarted
module frame_hdr_buf
  import udp_frame_pack_pkg::*;
#(
  parameter int N = DEF_HDR_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_sop_i,
  input  logic        wr_eop_i,
  input  logic        rd_adv_i,
  input  logic        clr_err_i,
  output logic [31:0] rd_data_o,
  output logic        rd_first_o,
  output logic        rd_last_o,
  output logic        done_o,
  output logic        hdr_err_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW:0]   CNT_LAST = (IW+1)'(N - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam bit SINGLE = (N == 1);

  logic [31:0]   buf_q [N];
  logic [31:0]   buf_d [N];
  logic [IW:0]   wr_cnt_q, wr_cnt_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic          hdr_err_q, hdr_err_d;

  // Write side: store words, detect completion and malformed headers
  always_comb begin
    buf_d     = buf_q;
    wr_cnt_d  = wr_cnt_q;
    hdr_err_d = hdr_err_q;
    done_o    = 1'b0;
    if (clr_err_i) begin
      hdr_err_d = 1'b0;
    end else begin
      hdr_err_d = hdr_err_q;
    end
    if (wr_en_i) begin
      if (wr_sop_i) begin
        // sop always (re)starts at slot 0; other slots cleared so a short
        // header reads back zeros in the unfilled positions
        for (int i = 1; i < N; i++) begin
          buf_d[i] = 32'd0;
        end
        buf_d[0] = wr_data_i;
        if (wr_cnt_q != '0) begin
          hdr_err_d = 1'b1;
        end else begin
          hdr_err_d = hdr_err_d;
        end
        if (SINGLE) begin
          done_o   = 1'b1;
          wr_cnt_d = '0;
        end else if (wr_eop_i) begin
          done_o    = 1'b1;
          wr_cnt_d  = '0;
          hdr_err_d = 1'b1;
        end else begin
          wr_cnt_d = (IW+1)'(1);
        end
      end else if (wr_cnt_q == '0) begin
        // stray word before any sop: dropped
        wr_cnt_d = '0;
      end else begin
        buf_d[wr_cnt_q[IW-1:0]] = wr_data_i;
        if (wr_cnt_q == CNT_LAST) begin
          done_o   = 1'b1;
          wr_cnt_d = '0;
        end else if (wr_eop_i) begin
          done_o    = 1'b1;
          wr_cnt_d  = '0;
          hdr_err_d = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q + (IW+1)'(1);
        end
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // Read side: index wraps to 0 after the last slot is sent
  always_comb begin
    if (rd_adv_i) begin
      if (rd_idx_q == IDX_LAST) begin
        rd_idx_d = '0;
      end else begin
        rd_idx_d = rd_idx_q + IW'(1);
      end
    end else begin
      rd_idx_d = rd_idx_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= 32'd0;
      end
      wr_cnt_q  <= '0;
      rd_idx_q  <= '0;
      hdr_err_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_idx_q  <= rd_idx_d;
      hdr_err_q <= hdr_err_d;
    end
  end

  assign rd_data_o  = buf_q[rd_idx_q];
  assign rd_first_o = (rd_idx_q == '0);
  assign rd_last_o  = (rd_idx_q == IDX_LAST);
  assign hdr_err_o  = hdr_err_q;

endmodule

// File: rtl/udp_frame_packer.sv
// UDP frame packer: joins a buffered header and a pass-through data stream
// into one Avalon-ST packet, forces the data length and appends a status
// trailer (bkg_sub_on, len_err, hdr_err, frame counter).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bkg_sub_on   background-subtraction-active flag
//   hdr_in       header sink  (empty ignored)
//   data_in      data sink    (empty ignored)
//   out          packet source (empty always 0)
module udp_frame_packer
  import udp_frame_pack_pkg::*;
#(
  parameter int HDR_WORDS  = DEF_HDR_WORDS,
  parameter int DATA_WORDS = DEF_DATA_WORDS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bkg_sub_on,
  udp_frame_packer_if.slave   hdr_in,
  udp_frame_packer_if.slave   data_in,
  udp_frame_packer_if.master  out
);

  localparam int DCW = $clog2(DATA_WORDS + 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(DATA_WORDS - 1);

  logic [2:0]        state_q, state_d;
  logic [DCW-1:0]    d_cnt_q, d_cnt_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              len_err_q, len_err_d;
  logic              bkg_q, bkg_d;
  logic              active_q;

  logic        hdr_ready_s, data_ready_s;
  logic        out_valid_s, out_sop_s, out_eop_s;
  logic [31:0] out_data_s;
  logic        hdr_wr_s, out_hs_s, data_hs_s;
  logic        rd_adv_s, clr_err_s;
  logic [31:0] hdr_rd_data_s;
  logic        hdr_rd_first_s, hdr_rd_last_s, hdr_done_s, hdr_err_s;
  logic        unused_empty_s;

  assign unused_empty_s = ^{hdr_in.empty, data_in.empty};

  assign hdr_wr_s  = hdr_in.valid && hdr_ready_s;
  assign out_hs_s  = out_valid_s && out.ready;
  assign data_hs_s = data_in.valid && data_ready_s;
  assign rd_adv_s  = (state_q == S_HDR) && out_hs_s;
  assign clr_err_s = (state_q == S_TRAIL) && out_hs_s;

  frame_hdr_buf #(
    .N (HDR_WORDS)
  ) u_hdr_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (hdr_wr_s),
    .wr_data_i  (hdr_in.data),
    .wr_sop_i   (hdr_in.startofpacket),
    .wr_eop_i   (hdr_in.endofpacket),
    .rd_adv_i   (rd_adv_s),
    .clr_err_i  (clr_err_s),
    .rd_data_o  (hdr_rd_data_s),
    .rd_first_o (hdr_rd_first_s),
    .rd_last_o  (hdr_rd_last_s),
    .done_o     (hdr_done_s),
    .hdr_err_o  (hdr_err_s)
  );

  // Output mux and ready generation, driven from the current state
  always_comb begin
    hdr_ready_s  = 1'b0;
    data_ready_s = 1'b0;
    out_valid_s  = 1'b0;
    out_sop_s    = 1'b0;
    out_eop_s    = 1'b0;
    out_data_s   = 32'd0;
    case (state_q)
      S_COLLECT: begin
        // held low for the first cycle after reset release
        hdr_ready_s = active_q;
      end
      S_HDR: begin
        out_valid_s = 1'b1;
        out_data_s  = hdr_rd_data_s;
        out_sop_s   = hdr_rd_first_s;
      end
      S_DATA: begin
        out_valid_s  = data_in.valid;
        out_data_s   = data_in.data;
        data_ready_s = out.ready;
      end
      S_PAD: begin
        out_valid_s = 1'b1;
      end
      S_DRAIN: begin
        data_ready_s = 1'b1;
      end
      S_TRAIL: begin
        out_valid_s = 1'b1;
        out_eop_s   = 1'b1;
        out_data_s  = build_trailer(bkg_q, len_err_q, hdr_err_s, frame_cnt_q);
      end
      default: begin
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Next-state logic: FSM, data counter, flags, frame counter
  always_comb begin
    state_d     = state_q;
    d_cnt_d     = d_cnt_q;
    frame_cnt_d = frame_cnt_q;
    len_err_d   = len_err_q;
    bkg_d       = bkg_q;
    case (state_q)
      S_COLLECT: begin
        if (hdr_done_s) begin
          state_d = S_HDR;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_HDR: begin
        if (out_hs_s && hdr_rd_last_s) begin
          state_d = S_DATA;
          d_cnt_d = '0;
        end else begin
          state_d = S_HDR;
        end
      end
      S_DATA: begin
        if (data_hs_s) begin
          d_cnt_d = d_cnt_q + DCW'(1);
          if (d_cnt_q == '0) begin
            bkg_d = bkg_sub_on;
          end else begin
            bkg_d = bkg_q;
          end
          if (d_cnt_q == D_LAST) begin
            if (data_in.endofpacket) begin
              state_d = S_TRAIL;
            end else begin
              // too long: swallow the rest up to eop
              state_d   = S_DRAIN;
              len_err_d = 1'b1;
            end
          end else if (data_in.endofpacket) begin
            // too short: zero-fill the remaining slots
            state_d   = S_PAD;
            len_err_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PAD: begin
        if (out_hs_s) begin
          d_cnt_d = d_cnt_q + DCW'(1);
          if (d_cnt_q == D_LAST) begin
            state_d = S_TRAIL;
          end else begin
            state_d = S_PAD;
          end
        end else begin
          state_d = S_PAD;
        end
      end
      S_DRAIN: begin
        if (data_hs_s && data_in.endofpacket) begin
          state_d = S_TRAIL;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_TRAIL: begin
        if (out_hs_s) begin
          frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          len_err_d   = 1'b0;
          d_cnt_d     = '0;
          state_d     = S_COLLECT;
        end else begin
          state_d = S_TRAIL;
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      d_cnt_q     <= '0;
      frame_cnt_q <= '0;
      len_err_q   <= 1'b0;
      bkg_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_cnt_q     <= d_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      len_err_q   <= len_err_d;
      bkg_q       <= bkg_d;
      active_q    <= 1'b1;
    end
  end

  assign out.data          = out_data_s;
  assign out.valid         = out_valid_s;
  assign out.startofpacket = out_sop_s;
  assign out.endofpacket   = out_eop_s;
  assign out.empty         = 2'd0;
  assign hdr_in.ready      = hdr_ready_s;
  assign data_in.ready     = data_ready_s;

endmodule

// File: tb/tb_udp_frame_packer.sv
// Scoreboard testbench for udp_frame_packer: drivers push the expected output
// words into a queue, a monitor pops and compares on every output handshake.
module tb_udp_frame_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bkg_sub_on = 1'b0;
  logic rnd_mode = 1'b0;

  udp_frame_packer_if hdr_if ();
  udp_frame_packer_if data_if ();
  udp_frame_packer_if out_if ();

  udp_frame_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bkg_sub_on (bkg_sub_on),
    .hdr_in     (hdr_if),
    .data_in    (data_if),
    .out        (out_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q [$];
  logic [26:0] exp_fcnt = 27'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every output handshake with the scoreboard head
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_if.valid && out_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %h expected none at %0t", out_if.data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", 64'({out_if.startofpacket, out_if.endofpacket, out_if.data}), 64'(e));
        end
        chk("out_empty", 64'(out_if.empty), 64'd0);
      end
    end
  end

  // out_ready driver: constant 1 or 50% random
  initial begin
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic hdr_word(input logic [31:0] d, input logic s, input logic e);
    logic acc;
    int n;
    hdr_if.data = d;
    hdr_if.startofpacket = s;
    hdr_if.endofpacket = e;
    hdr_if.valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = hdr_if.ready;
      @(posedge clk);
      #1;
      n++;
    end
    hdr_if.valid = 1'b0;
    hdr_if.startofpacket = 1'b0;
    hdr_if.endofpacket = 1'b0;
    chk("hdr_accept", 64'(acc), 64'd1);
  endtask

  task automatic data_word(input logic [31:0] d, input logic s, input logic e);
    logic acc;
    int n;
    data_if.data = d;
    data_if.startofpacket = s;
    data_if.endofpacket = e;
    data_if.valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = data_if.ready;
      @(posedge clk);
      #1;
      n++;
    end
    data_if.valid = 1'b0;
    data_if.startofpacket = 1'b0;
    data_if.endofpacket = 1'b0;
    chk("data_accept", 64'(acc), 64'd1);
  endtask

  // Header modes: 0 normal, 1 eop on word 2, 2 sop repeated, 3 stray word first
  task automatic send_hdr(input int mode);
    case (mode)
      1: begin
        hdr_word(32'hA0000001, 1'b1, 1'b0);
        hdr_word(32'hA0000002, 1'b0, 1'b1);
      end
      2: begin
        hdr_word(32'hA0000001, 1'b1, 1'b0);
        hdr_word(32'hA0000002, 1'b0, 1'b0);
        hdr_word(32'hA0000003, 1'b1, 1'b0);
        hdr_word(32'hA0000004, 1'b0, 1'b0);
        hdr_word(32'hA0000005, 1'b0, 1'b1);
      end
      3: begin
        hdr_word(32'hDEADBEEF, 1'b0, 1'b0);
        hdr_word(32'hA0000001, 1'b1, 1'b0);
        hdr_word(32'hA0000002, 1'b0, 1'b0);
        hdr_word(32'hA0000003, 1'b0, 1'b1);
      end
      default: begin
        hdr_word(32'hA0000001, 1'b1, 1'b0);
        hdr_word(32'hA0000002, 1'b0, 1'b0);
        hdr_word(32'hA0000003, 1'b0, 1'b1);
      end
    endcase
  endtask

  task automatic send_data(input int n_data);
    for (int i = 0; i < n_data; i++) begin
      data_word(32'(i + 1), (i == 0), (i == n_data - 1));
    end
  endtask

  task automatic push_hdr_exp(input int mode);
    logic [31:0] h0, h1, h2;
    if (mode == 1) begin
      h0 = 32'hA0000001; h1 = 32'hA0000002; h2 = 32'd0;
    end else if (mode == 2) begin
      h0 = 32'hA0000003; h1 = 32'hA0000004; h2 = 32'hA0000005;
    end else begin
      h0 = 32'hA0000001; h1 = 32'hA0000002; h2 = 32'hA0000003;
    end
    exp_q.push_back({2'b10, h0});
    exp_q.push_back({2'b00, h1});
    exp_q.push_back({2'b00, h2});
  endtask

  task automatic push_exp(input int mode, input int n_data, input logic bkg);
    logic he, le;
    push_hdr_exp(mode);
    for (int i = 0; i < 160; i++) begin
      exp_q.push_back({2'b00, (i < n_data) ? 32'(i + 1) : 32'd0});
    end
    he = (mode == 1 || mode == 2);
    le = (n_data != 160);
    exp_q.push_back({1'b0, 1'b1, bkg, le, he, 2'b00, exp_fcnt});
    exp_fcnt = exp_fcnt + 27'd1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("frame_drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_frame(input int mode, input int n_data, input logic bkg);
    bkg_sub_on = bkg;
    push_exp(mode, n_data, bkg);
    fork
      send_hdr(mode);
      send_data(n_data);
    join
    wait_drain();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_if.valid), 64'd0);
    chk("rst_hdr_ready", 64'(hdr_if.ready), 64'd0);
    exp_fcnt = 27'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    hdr_if.data = 32'd0; hdr_if.valid = 1'b0; hdr_if.startofpacket = 1'b0;
    hdr_if.endofpacket = 1'b0; hdr_if.empty = 2'd0;
    data_if.data = 32'd0; data_if.valid = 1'b0; data_if.startofpacket = 1'b0;
    data_if.endofpacket = 1'b0; data_if.empty = 2'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_if.valid), 64'd0);
    chk("reset_out_data", 64'(out_if.data), 64'd0);
    chk("reset_out_sop_eop", 64'({out_if.startofpacket, out_if.endofpacket}), 64'd0);
    chk("reset_hdr_ready", 64'(hdr_if.ready), 64'd0);
    chk("reset_data_ready", 64'(data_if.ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("release_hdr_ready_before_edge", 64'(hdr_if.ready), 64'd0);
    @(negedge clk);
    chk("release_hdr_ready_after_edge", 64'(hdr_if.ready), 64'd1);
    @(posedge clk);
    #1;

    // Nominal frame: trailer 0x80000000
    run_frame(0, 160, 1'b1);

    // Random backpressure over three frames, frame_cnt 0,1,2
    pulse_reset();
    rnd_mode = 1'b1;
    run_frame(0, 160, 1'b0);
    run_frame(3, 160, 1'b1);
    run_frame(0, 160, 1'b0);
    rnd_mode = 1'b0;

    // Short data, then a clean frame clearing len_err
    run_frame(0, 100, 1'b1);
    run_frame(0, 160, 1'b0);

    // Long data with backpressure
    rnd_mode = 1'b1;
    run_frame(0, 170, 1'b1);
    rnd_mode = 1'b0;

    // Malformed headers
    run_frame(1, 160, 1'b0);
    run_frame(2, 160, 1'b1);

    // Reset during data word 51
    bkg_sub_on = 1'b1;
    push_hdr_exp(0);
    for (int i = 0; i < 50; i++) begin
      exp_q.push_back({2'b00, 32'(i + 1)});
    end
    send_hdr(0);
    for (int i = 0; i < 50; i++) begin
      data_word(32'(i + 1), (i == 0), 1'b0);
    end
    data_if.data = 32'd51;
    data_if.valid = 1'b1;
    #1;
    chk("passthru_valid", 64'(out_if.valid), 64'd1);
    chk("passthru_data", 64'(out_if.data), 64'd51);
    chk("pre_reset_queue", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_if.valid), 64'd0);
    chk("midrst_out_data", 64'(out_if.data), 64'd0);
    chk("midrst_data_ready", 64'(data_if.ready), 64'd0);
    data_if.valid = 1'b0;
    exp_q.delete();
    exp_fcnt = 27'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_hdr_ready_back", 64'(hdr_if.ready), 64'd1);
    @(posedge clk);
    #1;
    run_frame(0, 160, 1'b1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
